// File: rtl/u109_reg_master_if.sv
// Command/response port and 68040-style local bus signals of the U109 register master.
// master modport faces the bus initiator; slave modport faces the command source and responder side.
`timescale 1ns/1ps
interface u109_reg_master_if;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_RnW;
  logic [3:0]  CMD_ADDR;
  logic [31:0] CMD_WDATA;
  logic        RSP_VALID;
  logic        RSP_ERR;
  logic [31:0] RSP_RDATA;
  logic        BRn;
  logic        BGn;
  logic        TSn;
  logic        RnW;
  logic [3:0]  REG_ADDRESS;
  logic [31:0] D_OUT;
  logic        D_OE;
  logic [31:0] D_IN;
  logic        TACK;

  modport master (
    input  CMD_VALID, CMD_RnW, CMD_ADDR, CMD_WDATA, BGn, D_IN, TACK,
    output CMD_READY, RSP_VALID, RSP_ERR, RSP_RDATA,
           BRn, TSn, RnW, REG_ADDRESS, D_OUT, D_OE
  );

  modport slave (
    output CMD_VALID, CMD_RnW, CMD_ADDR, CMD_WDATA, BGn, D_IN, TACK,
    input  CMD_READY, RSP_VALID, RSP_ERR, RSP_RDATA,
           BRn, TSn, RnW, REG_ADDRESS, D_OUT, D_OE
  );
endinterface

// File: rtl/u109_reg_master.sv
// Single-beat register read/write bus initiator toward the U109 bridge register responder.
// Optional timeout/error path is built when REG_MASTER_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module u109_reg_master #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic               CLK40,
  input logic               RESETn,
  u109_reg_master_if.master m_if
);

  // state   | meaning
  // IDLE    | ready for a command
  // REQ     | BRn low, waiting for grant
  // START   | TSn low for this one clock
  // WAIT    | waiting for TACK (or timeout)
  // DONE    | RSP_VALID strobe clock
  // RECOVER | one bus-idle clock before IDLE
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_START, S_WAIT, S_DONE, S_RECOVER
  } state_t;

  if (TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("u109_reg_master: TIMEOUT_CYCLES must be within 4..255");
  end

  state_t      r_state, w_state;
  logic        r_cmd_ready, w_cmd_ready;
  logic        r_rsp_valid, w_rsp_valid;
  logic        r_rsp_err, w_rsp_err;
  logic [31:0] r_rsp_rdata, w_rsp_rdata;
  logic        r_brn, w_brn;
  logic        r_tsn, w_tsn;
  logic        r_rnw, w_rnw;
  logic [3:0]  r_addr, w_addr;
  logic [31:0] r_dout, w_dout;
  logic        r_doe, w_doe;
  logic        w_tmo;

`ifdef REG_MASTER_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_cnt, w_cnt;
`endif

  always_comb begin
    w_state     = r_state;
    w_rsp_valid = 1'b0;
    w_rsp_err   = r_rsp_err;
    w_rsp_rdata = r_rsp_rdata;
    w_brn       = r_brn;
    w_tsn       = 1'b1;
    w_rnw       = r_rnw;
    w_addr      = r_addr;
    w_dout      = r_dout;
    w_doe       = r_doe;
    w_tmo       = 1'b0;
`ifdef REG_MASTER_TIMEOUT_EN
    w_cnt = r_cnt;
    if (r_state == S_REQ || r_state == S_START || r_state == S_WAIT) begin
      w_cnt = r_cnt + 8'd1;
      w_tmo = (r_cnt == TMO_LAST);
    end
`endif
    case (r_state)
      S_IDLE: begin
        if (m_if.CMD_VALID) begin
          w_rnw   = m_if.CMD_RnW;
          w_addr  = m_if.CMD_ADDR;
          w_dout  = m_if.CMD_WDATA;
          w_brn   = 1'b0;
`ifdef REG_MASTER_TIMEOUT_EN
          w_cnt   = '0;
`endif
          w_state = S_REQ;
        end
      end
      S_REQ: begin
        if (!w_tmo && !m_if.BGn) begin
          w_tsn   = 1'b0;
          w_doe   = !r_rnw;
          w_state = S_START;
        end
      end
      S_START: begin
        if (!w_tmo) w_state = S_WAIT;
      end
      S_WAIT: begin
        // TACK takes priority over a timeout landing on the same edge
        if (m_if.TACK) begin
          w_rsp_valid = 1'b1;
          w_rsp_err   = 1'b0;
          w_rsp_rdata = r_rnw ? m_if.D_IN : 32'h0;
          w_brn       = 1'b1;
          w_doe       = 1'b0;
          w_rnw       = 1'b1;
          w_state     = S_DONE;
        end
      end
      S_DONE:    w_state = S_RECOVER;
      S_RECOVER: w_state = S_IDLE;
      default:   w_state = S_IDLE;
    endcase
    // Timeout path: REQ/START/WAIT without TACK reaching the terminal count
    if (w_tmo && !(r_state == S_WAIT && m_if.TACK)) begin
      w_rsp_valid = 1'b1;
      w_rsp_err   = 1'b1;
      w_rsp_rdata = 32'hFFFF_FFFF;
      w_brn       = 1'b1;
      w_tsn       = 1'b1;
      w_doe       = 1'b0;
      w_rnw       = 1'b1;
      w_state     = S_DONE;
    end
    w_cmd_ready = (w_state == S_IDLE);
  end

  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_brn       <= 1'b1;
      r_tsn       <= 1'b1;
      r_rnw       <= 1'b1;
      r_addr      <= 4'h0;
      r_dout      <= 32'h0;
      r_doe       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cmd_ready <= w_cmd_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
      r_rsp_rdata <= w_rsp_rdata;
      r_brn       <= w_brn;
      r_tsn       <= w_tsn;
      r_rnw       <= w_rnw;
      r_addr      <= w_addr;
      r_dout      <= w_dout;
      r_doe       <= w_doe;
    end
  end

`ifdef REG_MASTER_TIMEOUT_EN
  always_ff @(posedge CLK40) begin
    if (!RESETn) r_cnt <= '0;
    else         r_cnt <= w_cnt;
  end
`endif

  assign m_if.CMD_READY   = r_cmd_ready;
  assign m_if.RSP_VALID   = r_rsp_valid;
  assign m_if.RSP_ERR     = r_rsp_err;
  assign m_if.RSP_RDATA   = r_rsp_rdata;
  assign m_if.BRn         = r_brn;
  assign m_if.TSn         = r_tsn;
  assign m_if.RnW         = r_rnw;
  assign m_if.REG_ADDRESS = r_addr;
  assign m_if.D_OUT       = r_dout;
  assign m_if.D_OE        = r_doe;

endmodule

// File: doc/u109_reg_master.md
# u109_reg_master

Bus initiator that issues single-beat register read/write cycles on the local 68040-style bus toward the bridge register responder, on behalf of an internal command port such as a boot-time init sequencer or a debug path. It requests the bus, drives one TSn transfer-start pulse with address, direction and write data, and waits for TACK. It then returns read data or an error on a one-cycle response strobe. It sits alongside the bridge register block in U109 and is that block's counterpart: the responder answers cycles, and this block originates them.

## Interface
- TIMEOUT_CYCLES, 64: clocks from command accept to forced error termination; only used when the timeout feature is compiled in; legal range 4..255.
- CLK40  in  1  system clock; all logic on rising edge.
- RESETn  in  1  reset, synchronous, active-low.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  high only in IDLE; accept edge is CMD_VALID && CMD_READY.
- CMD_RnW  in  1  1 = read, 0 = write.
- CMD_ADDR  in  4  register index (AD[5:2]).
- CMD_WDATA  in  32  write data.
- RSP_VALID  out  1  one-cycle completion strobe; no backpressure.
- RSP_ERR  out  1  qualifies RSP_VALID; 1 = timeout.
- RSP_RDATA  out  32  read data; held until next RSP_VALID.
- BRn  out  1  bus request, active-low.
- BGn  in  1  bus grant, active-low.
- TSn  out  1  transfer start, active-low, exactly one clock per cycle.
- RnW  out  1  bus direction.
- REG_ADDRESS  out  4  bus address AD[5:2].
- D_OUT  out  32  write data to bus.
- D_OE  out  1  D_OUT output enable; writes only.
- D_IN  in  32  read data from bus.
- TACK  in  1  transfer acknowledge, active-high, one clock.

## Operation
- Reset values: CMD_READY=1, RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0, BRn=1, TSn=1, RnW=1, REG_ADDRESS=0, D_OUT=0, D_OE=0. State is IDLE and the timeout counter is 0.
- IDLE: CMD_READY=1. On the accept edge, latch RnW, address and wdata into the bus outputs, set BRn=0, clear the counter, go to REQ.
- REQ: wait for BGn=0 sampled. Then set TSn=0, and set D_OE=1 if the cycle is a write. Go to START.
- START: TSn returns to 1 on the next edge. Go to WAIT.
- WAIT: on the edge where TACK=1 is sampled, set RSP_VALID=1 and RSP_ERR=0. For a read, capture D_IN into RSP_RDATA; for a write, load 0. Release the bus (BRn=1, D_OE=0, RnW=1). Go to DONE.
- DONE: RSP_VALID=0. Go to RECOVER.
- RECOVER: one bus-idle clock. Go to IDLE. CMD_READY rises on the edge that enters IDLE.
- Timeout (macro on): the counter increments every clock in REQ, START and WAIT. On reaching TIMEOUT_CYCLES without TACK: RSP_VALID=1, RSP_ERR=1, RSP_RDATA=32'hFFFF_FFFF, bus released, go to DONE. TSn is forced to 1 if a timeout fires in START.
- TACK sampled in IDLE, REQ or DONE is ignored.
- If TACK and the terminal count occur on the same edge, TACK wins: normal completion with RSP_ERR=0.
- Loss of grant (BGn=1) after TSn is ignored; the cycle completes on TACK.
- RESETn low at any state: all outputs take their reset values on that edge, and the in-flight cycle is abandoned with no RSP_VALID.

## Timing
- REG_ADDRESS, RnW and D_OUT are stable from the accept edge through the TACK edge. D_OE is high from the TSn-assert edge through the TACK edge.
- With BGn held low, the accept edge is at e0, TSn is low during e1..e2, and the earliest legal TACK is sampled at e3.
- Against the register responder, which returns TACK 2 clocks after sampling TSn, RSP_VALID is high during e4..e5 and CMD_READY returns to 1 at e6. The back-to-back command period is 6 clocks.
- RSP_RDATA equals the D_IN value present at the TACK edge.

## Configuration
- REG_MASTER_TIMEOUT_EN defined: the timeout counter and error path are built, and RSP_ERR can be 1.
- REG_MASTER_TIMEOUT_EN undefined: the counter is removed, REQ and WAIT wait indefinitely, RSP_ERR is tied to 0, and TIMEOUT_CYCLES is unused.

## Test plan
- Read idx 0: BGn=0, responder model returns D_IN=32'hC4D2_0258 with TACK 2 clocks after TSn. Required: TSn low for exactly 1 clock, RnW=1, D_OE=0; RSP_VALID for 1 clock at e4 with RSP_RDATA=32'hC4D2_0258 and RSP_ERR=0.
- Write idx 0, wdata 32'h4000_0000: required D_OE=1 and D_OUT=32'h4000_0000 from TSn through TACK; RSP_RDATA=0; RnW=0 during the cycle and 1 after.
- Grant delay: BGn held high for 10 clocks after accept. Required: BRn=0 throughout, TSn stays high until the clock after BGn falls, and CMD_READY stays 0.
- Timeout (macro on, TIMEOUT_CYCLES=8), no TACK: required RSP_VALID with RSP_ERR=1 and RSP_RDATA=32'hFFFF_FFFF 8 clocks after accept, and BRn=1 on the same edge. Repeat with TACK on the 8th edge: required RSP_ERR=0.
- Reset mid-WAIT: RESETn low for 1 clock. Required: all outputs at reset values the next clock, no RSP_VALID, and a new command accepted and completed normally afterwards.
- Back-to-back reads of idx 2 with CMD_VALID held high: required a 6-clock period, RSP_RDATA=32'h0600_0000 each time, and no TSn during DONE or RECOVER.
